// File: rtl/ascon_reg_master.sv
`default_nettype none
// ============================================================================
//  Module   : ascon_reg_master
//  Purpose  : Register-bus initiator for the ASCON accelerator. Writes a
//             320-bit state as 10 x 32-bit words, sets the start bit, polls
//             STATUS until idle, reads the 10 words back and presents them.
//  Options  : ASCON_REG_MASTER_TIMEOUT_EN bounds STATUS polling to POLL_LIMIT
//             reads; without it polling is unbounded.
//  Revision : 1.0 - initial release
// ============================================================================

// Register-bus request/response shared with the accelerator's register slave.
typedef struct packed {
   logic [31:0] addr;
   logic        write;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        valid;
} reg_req_t;

typedef struct packed {
   logic [31:0] rdata;
   logic        error;
   logic        ready;
} reg_rsp_t;

module ascon_reg_master #(
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter logic [31:0] STATUS_OFFSET = 32'h0,
   parameter logic [31:0] STATE_OFFSET  = 32'h4,
   parameter int unsigned POLL_LIMIT    = 1024
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                in_valid_i,
   output logic                in_ready_o,
   input  logic [4:0][63:0]    in_state_i,
   output logic                out_valid_o,
   input  logic                out_ready_i,
   output logic [4:0][63:0]    out_state_o,
   output logic                out_err_o,
   output logic                busy_o,
   output reg_req_t            reg_req_o,
   input  reg_rsp_t            reg_rsp_i
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WR_STATE = 3'd1,
      S_WR_START = 3'd2,
      S_POLL     = 3'd3,
      S_RD_STATE = 3'd4,
      S_OUT      = 3'd5
   } state_t;

   localparam logic [3:0] C_LAST_WORD = 4'd9;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   // Both views are word-indexed: word 2k = lane k low half, 2k+1 = high half.
   logic [9:0][31:0]  in_q, in_d;
   logic [9:0][31:0]  res_q, res_d;
   logic              err_q, err_d;
   logic              xfer;
   logic [31:0]       word_addr;

`ifdef ASCON_REG_MASTER_TIMEOUT_EN
   logic [31:0]       poll_q, poll_d;
`else
   // Polling is unbounded in this build, so the limit has no consumer.
   logic              unused_poll_limit;
   assign unused_poll_limit = (POLL_LIMIT == 0);
`endif

   assign word_addr = BASE_ADDR + STATE_OFFSET + {26'd0, cnt_q, 2'b00};

   // Next-state, bus request and handshake outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      in_d        = in_q;
      res_d       = res_q;
      err_d       = err_q;
`ifdef ASCON_REG_MASTER_TIMEOUT_EN
      poll_d      = poll_q;
`endif
      reg_req_o   = '0;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      xfer        = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               in_d    = in_state_i;
               cnt_d   = 4'd0;
               err_d   = 1'b0;
`ifdef ASCON_REG_MASTER_TIMEOUT_EN
               poll_d  = 32'd0;
`endif
               state_d = S_WR_STATE;
            end
         end

         S_WR_STATE: begin
            reg_req_o.valid = 1'b1;
            reg_req_o.write = 1'b1;
            reg_req_o.addr  = word_addr;
            reg_req_o.wdata = in_q[cnt_q];
            reg_req_o.wstrb = 4'hF;
            xfer = reg_rsp_i.ready;
            if (xfer) begin
               if (reg_rsp_i.error) begin
                  err_d   = 1'b1;
                  state_d = S_OUT;
               end else if (cnt_q == C_LAST_WORD) begin
                  cnt_d   = 4'd0;
                  state_d = S_WR_START;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end

         S_WR_START: begin
            reg_req_o.valid = 1'b1;
            reg_req_o.write = 1'b1;
            reg_req_o.addr  = BASE_ADDR + STATUS_OFFSET;
            reg_req_o.wdata = 32'h1;
            reg_req_o.wstrb = 4'hF;
            xfer = reg_rsp_i.ready;
            if (xfer) begin
               if (reg_rsp_i.error) begin
                  err_d   = 1'b1;
                  state_d = S_OUT;
               end else begin
                  state_d = S_POLL;
               end
            end
         end

         S_POLL: begin
            reg_req_o.valid = 1'b1;
            reg_req_o.addr  = BASE_ADDR + STATUS_OFFSET;
            xfer = reg_rsp_i.ready;
            if (xfer) begin
               if (reg_rsp_i.error) begin
                  err_d   = 1'b1;
                  state_d = S_OUT;
               end else if (!reg_rsp_i.rdata[0]) begin
                  cnt_d   = 4'd0;
                  state_d = S_RD_STATE;
               end else begin
`ifdef ASCON_REG_MASTER_TIMEOUT_EN
                  poll_d = poll_q + 32'd1;
                  if (poll_q == 32'(POLL_LIMIT - 1)) begin
                     err_d   = 1'b1;
                     state_d = S_OUT;
                  end
`endif
               end
            end
         end

         S_RD_STATE: begin
            reg_req_o.valid = 1'b1;
            reg_req_o.addr  = word_addr;
            xfer = reg_rsp_i.ready;
            if (xfer) begin
               if (reg_rsp_i.error) begin
                  err_d   = 1'b1;
                  state_d = S_OUT;
               end else begin
                  res_d[cnt_q] = reg_rsp_i.rdata;
                  if (cnt_q == C_LAST_WORD) begin
                     state_d = S_OUT;
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end
            end
         end

         S_OUT: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         in_q    <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
`ifdef ASCON_REG_MASTER_TIMEOUT_EN
         poll_q  <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         in_q    <= in_d;
         res_q   <= res_d;
         err_q   <= err_d;
`ifdef ASCON_REG_MASTER_TIMEOUT_EN
         poll_q  <= poll_d;
`endif
      end
   end

   assign busy_o      = (state_q != S_IDLE);
   assign out_err_o   = err_q;
   assign out_state_o = res_q;

endmodule

`default_nettype wire

// File: tb/tb_ascon_reg_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ascon_reg_master
//  Purpose  : Scoreboard bench for ascon_reg_master with a register-slave
//             model that returns the bitwise inverse of the written state.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ascon_reg_master;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [4:0][63:0] in_state_i;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [4:0][63:0] out_state_o;
   logic             out_err_o;
   logic             busy_o;
   reg_req_t         reg_req_o;
   reg_rsp_t         reg_rsp_i;

   ascon_reg_master #(
      .BASE_ADDR     (32'h0000_0000),
      .STATUS_OFFSET (32'h0),
      .STATE_OFFSET  (32'h4),
      .POLL_LIMIT    (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .in_state_i  (in_state_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_state_o (out_state_o),
      .out_err_o   (out_err_o),
      .busy_o      (busy_o),
      .reg_req_o   (reg_req_o),
      .reg_rsp_i   (reg_rsp_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      logic [319:0] st;
      bit           err;
   } out_t;

   bus_t exp_bus[$];
   out_t exp_out[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Slave configuration (written by stimulus, read by the slave model).
   logic [31:0] cfg_stall_addr  = 32'hFFFF_FFFF;
   int          cfg_stall_n     = 0;
   int          cfg_busy_n      = 0;    // STATUS reads returning 1; <0 = forever
   int          cfg_poll_budget = -1;   // STATUS reads the slave completes; <0 = all
   logic [31:0] cfg_err_addr    = 32'hFFFF_FFFF;

   // Slave-model state.
   logic [31:0] mem [10];
   bit          snap_xfer = 1'b0;
   reg_req_t    snap;
   int          status_reads = 0;
   int          stall_count = 0;
   int          stall_vcycles = 0;
   bit          stall_seen = 1'b0;
   reg_req_t    stall_first;
   bit          rdy;
   bus_t        eb;
   out_t        eo;
   logic [319:0] last_result = '0;
   logic [319:0] v1, v2, v3;

   task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      bus_t b;
      b.write = 1'b1; b.addr = a; b.wdata = d;
      exp_bus.push_back(b);
   endtask

   task automatic push_rd(input logic [31:0] a);
      bus_t b;
      b.write = 1'b0; b.addr = a; b.wdata = 32'h0;
      exp_bus.push_back(b);
   endtask

   // Expected bus sequence; err_word<0 means no write error, n_polls STATUS reads,
   // with_rd=0 stops after polling.
   task automatic push_txn(input logic [319:0] v, input int err_word, input int n_polls,
                           input bit with_rd);
      for (int w = 0; w < 10; w++) begin
         push_wr(32'd4 + 32'(4 * w), v[32*w +: 32]);
         if (w == err_word) return;
      end
      push_wr(32'h0, 32'h1);
      for (int p = 0; p < n_polls; p++) push_rd(32'h0);
      if (!with_rd) return;
      for (int w = 0; w < 10; w++) push_rd(32'd4 + 32'(4 * w));
   endtask

   task automatic push_out(input logic [319:0] st, input bit err);
      out_t o;
      o.st = st; o.err = err;
      exp_out.push_back(o);
      last_result = st;
   endtask

   task automatic send(input logic [319:0] v);
      @(posedge clk_i); #1;
      in_valid_i = 1'b1;
      in_state_i = v;
      @(posedge clk_i); #1;
      in_valid_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit done = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         @(posedge clk_i); #1;
         if (exp_bus.size() == 0 && exp_out.size() == 0 && !busy_o) done = 1'b1;
      end
      chk(name, {318'd0, done}, 320'd1);
   endtask

   // Monitor: slave responses, bus scoreboard and result scoreboard.
   task automatic monitor();
      forever begin
         @(negedge clk_i);
         if (snap_xfer) begin
            if (exp_bus.size() == 0) begin
               n_checks++;
               $display("FAIL bus_extra: got write=%0b addr=%0h, required no transfer",
                        snap.write, snap.addr);
            end else begin
               eb = exp_bus.pop_front();
               chk("bus_xfer", {snap.write, snap.addr, (snap.write ? snap.wdata : 32'h0),
                                (snap.write ? snap.wstrb : 4'hF)},
                               {eb.write, eb.addr, eb.wdata, 4'hF});
            end
            if (snap.write && snap.addr >= 32'd4 && snap.addr <= 32'd40)
               mem[(snap.addr - 32'd4) >> 2] = snap.wdata;
            if (!snap.write && snap.addr == 32'h0) status_reads++;
            if (cfg_stall_n > 0 && snap.write && snap.addr == cfg_stall_addr) begin
               chk("stall_len", 320'(stall_vcycles), 320'(cfg_stall_n + 1));
               chk("stall_stable", 320'(snap), 320'(stall_first));
            end
         end
         if (out_valid_o && out_ready_i) begin
            if (exp_out.size() == 0) begin
               n_checks++;
               $display("FAIL out_extra: got out_err=%0b, required no result", out_err_o);
            end else begin
               eo = exp_out.pop_front();
               chk("out_state", out_state_o, eo.st);
               chk("out_err", {319'd0, out_err_o}, {319'd0, eo.err});
            end
         end
         snap_xfer = 1'b0;
         reg_rsp_i = '0;
         if (!busy_o) begin
            status_reads = 0; stall_count = 0; stall_vcycles = 0; stall_seen = 1'b0;
         end
         if (reg_req_o.valid && !rst_i) begin
            rdy = 1'b1;
            if (reg_req_o.write && reg_req_o.addr == cfg_stall_addr) begin
               stall_vcycles++;
               if (!stall_seen) begin stall_first = reg_req_o; stall_seen = 1'b1; end
               if (stall_count < cfg_stall_n) begin rdy = 1'b0; stall_count++; end
            end
            if (!reg_req_o.write && reg_req_o.addr == 32'h0 && cfg_poll_budget >= 0 &&
                status_reads >= cfg_poll_budget) rdy = 1'b0;
            reg_rsp_i.ready = rdy;
            reg_rsp_i.error = reg_req_o.write && (reg_req_o.addr == cfg_err_addr);
            if (!reg_req_o.write) begin
               if (reg_req_o.addr == 32'h0)
                  reg_rsp_i.rdata = (cfg_busy_n < 0 || status_reads < cfg_busy_n) ? 32'h1 : 32'h0;
               else if (reg_req_o.addr >= 32'd4 && reg_req_o.addr <= 32'd40)
                  reg_rsp_i.rdata = ~mem[(reg_req_o.addr - 32'd4) >> 2];
            end
            snap_xfer = rdy;
            snap      = reg_req_o;
         end
      end
   endtask

   task automatic stimulus();
      for (int i = 0; i < 5; i++) v1[64*i +: 64] = 64'h0123_4567_89AB_CDEF + 64'(i);
      v2 = {64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_F0F0_F0F0, 64'hDEAD_BEEF_CAFE_F00D,
            64'h8000_0000_0000_0001, 64'h5555_AAAA_3333_CCCC};
      v3 = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC,
            64'hDDDD_EEEE_FFFF_0000, 64'h0000_0000_1234_5678};
      for (int i = 0; i < 10; i++) mem[i] = 32'h0;

      rst_i = 1'b1; in_valid_i = 1'b0; in_state_i = '0; out_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_in_ready", {319'd0, in_ready_o}, 320'd1);
      chk("rst_out_valid", {318'd0, out_valid_o, out_err_o}, 320'd0);
      chk("rst_busy", {319'd0, busy_o}, 320'd0);
      chk("rst_out_state", out_state_o, 320'd0);
      chk("rst_req", 320'(reg_req_o), 320'd0);
      rst_i = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk_i); #1;
         chk("idle", {317'd0, in_ready_o, reg_req_o.valid, out_valid_o}, {317'd0, 3'b100});
      end
      chk("word0_v1", 320'(v1[31:0]), 320'h89AB_CDEF);
      chk("word1_v1", 320'(v1[63:32]), 320'h0123_4567);

      // Zero-wait slave, single poll.
      push_txn(v1, -1, 1, 1'b1);
      push_out(~v1, 1'b0);
      send(v1);
      chk("in_ready_fall", {319'd0, in_ready_o}, 320'd0);
      wait_done("done_basic");

      // Stall on word 5, 7 busy polls, result held while out_ready_i=0.
      cfg_stall_addr = 32'd24; cfg_stall_n = 3; cfg_busy_n = 7;
      out_ready_i = 1'b0;
      push_txn(v2, -1, 8, 1'b1);
      push_out(~v2, 1'b0);
      send(v2);
      for (int c = 0; c < 200 && !out_valid_o; c++) begin @(posedge clk_i); #1; end
      repeat (3) @(posedge clk_i);
      #1;
      chk("out_hold", {318'd0, out_valid_o, busy_o}, 320'd3);
      out_ready_i = 1'b1;
      wait_done("done_stall");
      cfg_stall_addr = 32'hFFFF_FFFF; cfg_stall_n = 0; cfg_busy_n = 0;

      // Error on write of word 3: no start write, prior result retained.
      cfg_err_addr = 32'd16;
      push_txn(v3, 3, 0, 1'b0);
      push_out(last_result, 1'b1);
      send(v3);
      wait_done("done_err");
      chk("err_held_idle", {319'd0, out_err_o}, 320'd1);
      cfg_err_addr = 32'hFFFF_FFFF;

      // Next accepted input clears the error.
      push_txn(v3, -1, 1, 1'b1);
      push_out(~v3, 1'b0);
      send(v3);
      chk("err_cleared", {319'd0, out_err_o}, 320'd0);
      wait_done("done_v3");

`ifdef ASCON_REG_MASTER_TIMEOUT_EN
      // STATUS stuck at 1: POLL_LIMIT reads then timeout, no readback.
      cfg_busy_n = -1;
      push_txn(v1, -1, 4, 1'b0);
      push_out(last_result, 1'b1);
      send(v1);
      wait_done("done_timeout");
      cfg_busy_n = 0;
`endif

      // Reset while a STATUS read is pending.
      cfg_busy_n = -1; cfg_poll_budget = 3;
      push_txn(v2, -1, 3, 1'b0);
      send(v2);
      for (int c = 0; c < 200 && exp_bus.size() != 0; c++) begin @(posedge clk_i); #1; end
      repeat (2) @(posedge clk_i);
      #1;
      chk("poll_pending", {318'd0, busy_o, reg_req_o.valid}, 320'd3);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      chk("rst_mid_poll", {318'd0, reg_req_o.valid, in_ready_o}, 320'd1);
      chk("rst_mid_state", out_state_o, 320'd0);
      chk("rst_mid_queue", 320'(exp_bus.size()), 320'd0);
      rst_i = 1'b0;
      cfg_busy_n = 0; cfg_poll_budget = -1;
      last_result = '0;

      // Recovery after reset.
      push_txn(v1, -1, 1, 1'b1);
      push_out(~v1, 1'b0);
      send(v1);
      wait_done("done_recover");
      repeat (3) @(posedge clk_i);
   endtask

   initial begin
      reg_rsp_i = '0;
      fork
         monitor();
         stimulus();
      join_any
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
